obi_mem_responder: RTL

OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

---
 rtl/obi_mem_responder.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/obi_mem_responder.sv
// OBI memory slave with configurable grant wait, response latency and outstanding limit.
// Define OBI_RESP_STATS_EN to add saturating granted read/write counters (rd_count_o, wr_count_o).
package obi_mem_responder_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mem_responder
  import obi_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 64,
  parameter int unsigned GNT_WAIT  = 0,
  parameter int unsigned RESP_LAT  = 1,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  obi_req_t  slave_req_i,
  output obi_resp_t slave_resp_o
`ifdef OBI_RESP_STATS_EN
  ,
  output logic [15:0] rd_count_o,
  output logic [15:0] wr_count_o
`endif
);

  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);
  localparam logic [31:0] SPAN      = 32'(NUM_WORDS * 4);
  localparam logic [2:0]  WAIT_LAST = (GNT_WAIT > 0) ? 3'(GNT_WAIT - 1) : 3'd0;
  localparam logic [2:0]  OUTST_MAX = 3'(MAX_OUTST);
  localparam logic [31:0] OOR_DATA  = 32'hBADC_AB1E;

  typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_e;

  state_e           state_q, state_d;
  logic [2:0]       wait_q, wait_d;
  logic [2:0]       outst_q;
  logic             gnt;
  logic             rvalid;
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0]      resp_data;

  logic [31:0]         mem [NUM_WORDS];
  logic [RESP_LAT-1:0] valid_q;
  logic [31:0]         data_q [RESP_LAT];

  // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fall out of range.
  assign offset   = slave_req_i.addr - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign idx      = offset[IDX_W+1:2];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    wait_d  = wait_q;
    gnt     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (slave_req_i.req) begin
          if (GNT_WAIT == 0) state_d = GRANT;
          else               state_d = WAIT;
        end
      end
      WAIT: begin
        if (!slave_req_i.req) begin
          state_d = IDLE;
          wait_d  = '0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = GRANT;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      GRANT: begin
        gnt = slave_req_i.req && (outst_q < OUTST_MAX);
        if (gnt && GNT_WAIT != 0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_ni) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outst_q <= '0;
    end else begin
      unique case ({gnt, rvalid})
        2'b10:   outst_q <= outst_q + 3'd1;
        2'b01:   outst_q <= outst_q - 3'd1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  // NOTE: storage is deliberately left without reset; only control state is cleared.
  always_ff @(posedge clk_i) begin
    if (gnt && slave_req_i.we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_req_i.be[b]) mem[idx][8*b +: 8] <= slave_req_i.wdata[8*b +: 8];
      end
    end
  end

  // Read data is captured at the grant edge; writes answer with zero data.
  always_comb begin
    resp_data = '0;
    if (!slave_req_i.we) resp_data = in_range ? mem[idx] : OOR_DATA;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < RESP_LAT; i++) data_q[i] <= '0;
    end else begin
      valid_q[0] <= gnt;
      data_q[0]  <= resp_data;
      for (int i = 1; i < RESP_LAT; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

  assign rvalid = valid_q[RESP_LAT-1];

  always_comb begin
    slave_resp_o        = '0;
    slave_resp_o.gnt    = gnt;
    slave_resp_o.rvalid = rvalid;
    slave_resp_o.rdata  = rvalid ? data_q[RESP_LAT-1] : 32'h0;
  end

`ifdef OBI_RESP_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if (gnt) begin
      if (!slave_req_i.we && rd_count_o != 16'hFFFF) rd_count_o <= rd_count_o + 16'd1;
      if (slave_req_i.we && wr_count_o != 16'hFFFF)  wr_count_o <= wr_count_o + 16'd1;
    end
  end
`endif

endmodule
